// File: rtl/tlul_host_arb2_if.sv
// TL-UL channel types and the bundle of host/device ports seen by the two-host arbiter.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [7:0]  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [7:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

interface tlul_host_arb2_if;
    tlul_pkg::tl_h2d_t h0_req_i;
    tlul_pkg::tl_d2h_t h0_rsp_o;
    tlul_pkg::tl_h2d_t h1_req_i;
    tlul_pkg::tl_d2h_t h1_rsp_o;
    tlul_pkg::tl_h2d_t dev_req_o;
    tlul_pkg::tl_d2h_t dev_rsp_i;

    // slave: the arbiter; master: whatever drives the hosts and models the device
    modport slave (
        input  h0_req_i, h1_req_i, dev_rsp_i,
        output h0_rsp_o, h1_rsp_o, dev_req_o
    );
    modport master (
        output h0_req_i, h1_req_i, dev_rsp_i,
        input  h0_rsp_o, h1_rsp_o, dev_req_o
    );
endinterface

// File: rtl/tlul_host_arb2.sv
// Round-robin arbiter sharing one TL-UL device port between two hosts, one transaction in
// flight, with a device-response timeout that returns a synthesized error to the owner.
module tlul_host_arb2 #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tlul_host_arb2_if.slave   bus,
    output logic [1:0]        gnt_o,
    output logic              timeout_o
);
    import tlul_pkg::*;

    typedef enum logic [2:0] {IDLE, ADDR, RESP, ERR, DRAIN} state_e;

    // TIMEOUT_CYCLES must fit in CNT_W bits.
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

    state_e           state_q;
    logic             owner_q;
    logic             last_q;
    logic [1:0]       gnt_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       lat_source_q;
    logic [1:0]       lat_size_q;
    logic [2:0]       lat_opcode_q;

    tl_h2d_t host_req [2];
    tl_d2h_t host_rsp [2];
    tl_h2d_t own_req;
    tl_h2d_t win_req;
    tl_h2d_t dev_req;
    tl_d2h_t own_rsp;
    logic    grant_win;

    assign host_req[0]   = bus.h0_req_i;
    assign host_req[1]   = bus.h1_req_i;
    assign bus.h0_rsp_o  = host_rsp[0];
    assign bus.h1_rsp_o  = host_rsp[1];
    assign bus.dev_req_o = dev_req;
    assign gnt_o         = gnt_q;
    assign timeout_o     = timeout_q;

    // On a tie the host that did not win last time goes first.
    assign grant_win = (host_req[0].a_valid & host_req[1].a_valid) ? ~last_q
                                                                   : host_req[1].a_valid;
    assign win_req   = host_req[grant_win];
    assign own_req   = host_req[owner_q];

    always_comb begin
        dev_req = '0;
        own_rsp = '0;
        case (state_q)
            ADDR: begin
                dev_req         = own_req;
                dev_req.d_ready = 1'b0;
                own_rsp.a_ready = bus.dev_rsp_i.a_ready;
            end
            RESP: begin
                dev_req.d_ready = own_req.d_ready;
                own_rsp         = bus.dev_rsp_i;
                own_rsp.a_ready = 1'b0;
            end
            ERR: begin
                own_rsp.d_valid  = 1'b1;
                own_rsp.d_error  = 1'b1;
                own_rsp.d_data   = '1;
                own_rsp.d_source = lat_source_q;
                own_rsp.d_size   = lat_size_q;
                own_rsp.d_opcode = (lat_opcode_q == Get) ? AccessAckData : AccessAck;
            end
            DRAIN: begin
                dev_req.d_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Only the owner ever sees channel activity; own_rsp is all-zero outside ADDR/RESP/ERR.
    for (genvar gi = 0; gi < 2; gi++) begin : g_host_rsp
        assign host_rsp[gi] = (owner_q == 1'(gi)) ? own_rsp : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            gnt_q        <= 2'b00;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
            lat_source_q <= '0;
            lat_size_q   <= '0;
            lat_opcode_q <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (host_req[0].a_valid | host_req[1].a_valid) begin
                        owner_q      <= grant_win;
                        gnt_q        <= grant_win ? 2'b10 : 2'b01;
                        lat_source_q <= win_req.a_source;
                        lat_size_q   <= win_req.a_size;
                        lat_opcode_q <= win_req.a_opcode;
                        state_q      <= ADDR;
                    end
                end
                ADDR: begin
                    if (dev_req.a_valid & bus.dev_rsp_i.a_ready) begin
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // A response on the expiry cycle still completes normally.
                    if (bus.dev_rsp_i.d_valid) begin
                        if (own_req.d_ready) begin
                            last_q  <= owner_q;
                            gnt_q   <= 2'b00;
                            state_q <= IDLE;
                        end
                    end else if (TO_EN && (cnt_q == TO_LIMIT)) begin
                        timeout_q <= 1'b1;
                        state_q   <= ERR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ERR: begin
                    if (own_req.d_ready) begin
                        last_q  <= owner_q;
                        gnt_q   <= 2'b00;
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Absorb at most one late device response, bounded by the same timeout.
                    if (bus.dev_rsp_i.d_valid || (cnt_q >= TO_LIMIT)) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlul_host_arb2.sv
// Directed bench for tlul_host_arb2: two host queues, a delay-programmable device model and a
// per-host response scoreboard checked as responses appear.
module tb_tlul_host_arb2;
    import tlul_pkg::*;

    localparam int TO = 8;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  src;
    } req_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] data;
        logic        err;
        logic [7:0]  src;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gnt;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    int last_hs_edge = 0;

    req_t hq0[$];
    req_t hq1[$];
    exp_t eq0[$];
    exp_t eq1[$];
    int   gq[$];
    logic [6:0] seq0 = '0;
    logic [6:0] seq1 = '0;

    bit          dev_pending = 1'b0;
    bit          dev_silent  = 1'b0;
    bit          dev_late    = 1'b0;
    int          dev_delay   = 1;
    int          dev_due     = 0;
    logic [2:0]  dev_op      = '0;
    logic [31:0] dev_addr    = '0;
    logic [7:0]  dev_src     = '0;

    tlul_host_arb2_if bus();

    tlul_host_arb2 #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus.slave),
        .gnt_o     (gnt),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic tl_h2d_t drive_of(input req_t r, input bit v);
        tl_h2d_t t;
        t = '0;
        t.d_ready = 1'b1;
        if (v) begin
            t.a_valid   = 1'b1;
            t.a_opcode  = r.op;
            t.a_size    = 2'd2;
            t.a_source  = r.src;
            t.a_address = r.addr;
            t.a_mask    = 4'hF;
            t.a_data    = r.data;
            t.a_user    = r.addr[7:0];
        end
        return t;
    endfunction

    task automatic push_req(input int h, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input bit err);
        req_t r;
        exp_t e;
        r.op   = op;
        r.addr = addr;
        r.data = data;
        r.src  = (h == 1) ? {1'b1, seq1} : {1'b0, seq0};
        e.src  = r.src;
        e.err  = err;
        e.op   = (op == Get) ? AccessAckData : AccessAck;
        e.data = err ? 32'hFFFF_FFFF : ((op == Get) ? addr : 32'h0);
        if (h == 1) begin
            seq1++;
            hq1.push_back(r);
            eq1.push_back(e);
        end else begin
            seq0++;
            hq0.push_back(r);
            eq0.push_back(e);
        end
    endtask

    task automatic monitor();
        tl_h2d_t dq;
        tl_d2h_t dr;
        req_t    head;
        int      h;
        dq = bus.dev_req_o;
        dr = bus.dev_rsp_i;
        if (timeout) begin
            pulses++;
            chk("timeout_cycle", cyc, last_hs_edge + TO + 1);
        end
        if (dr.d_valid && dq.d_ready) dev_pending = 1'b0;
        if (dq.a_valid && dr.a_ready) begin
            h = int'(dq.a_source[7]);
            chk("grant_queued", gq.size() != 0, 1);
            if (gq.size() != 0) chk("grant_order", h, gq.pop_front());
            chk("gnt_owner", gnt, (h == 1) ? 2'b10 : 2'b01);
            head = '0;
            if (h == 1 && hq1.size() > 0) head = hq1[0];
            if (h == 0 && hq0.size() > 0) head = hq0[0];
            chk("a_address", dq.a_address, head.addr);
            chk("a_data", dq.a_data, head.data);
            chk("a_opcode", dq.a_opcode, head.op);
            chk("a_user", dq.a_user, head.addr[7:0]);
            chk("host_a_ready", (h == 1) ? bus.h1_rsp_o.a_ready : bus.h0_rsp_o.a_ready, 1);
            last_hs_edge = cyc + 1;
            dev_pending  = 1'b1;
            dev_late     = dev_silent;
            dev_due      = cyc + 1 + (dev_silent ? 12 : dev_delay);
            dev_op       = dq.a_opcode;
            dev_addr     = dq.a_address;
            dev_src      = dq.a_source;
        end
        for (int hi = 0; hi < 2; hi++) begin
            tl_h2d_t q;
            tl_d2h_t s;
            exp_t    e;
            int      n;
            q = (hi == 1) ? bus.h1_req_i : bus.h0_req_i;
            s = (hi == 1) ? bus.h1_rsp_o : bus.h0_rsp_o;
            if (s.d_valid && q.d_ready) begin
                n = (hi == 1) ? eq1.size() : eq0.size();
                chk($sformatf("rsp_expected_h%0d", hi), n != 0, 1);
                if (n != 0) begin
                    if (hi == 1) e = eq1.pop_front();
                    else         e = eq0.pop_front();
                    chk($sformatf("d_data_h%0d", hi), s.d_data, e.data);
                    chk($sformatf("d_error_h%0d", hi), s.d_error, e.err);
                    chk($sformatf("d_opcode_h%0d", hi), s.d_opcode, e.op);
                    chk($sformatf("d_source_h%0d", hi), s.d_source, e.src);
                    chk($sformatf("d_size_h%0d", hi), s.d_size, 2);
                    $display("txn host=%0d src=%02h op=%0d data=%08h err=%0d cycle=%0d",
                             hi, s.d_source, s.d_opcode, s.d_data, s.d_error, cyc);
                end
            end
            if (q.a_valid && s.a_ready) begin
                if (hi == 1) void'(hq1.pop_front());
                else         void'(hq0.pop_front());
            end
        end
    endtask

    task automatic step();
        tl_d2h_t d;
        @(posedge clk);
        #1;
        bus.h0_req_i = (hq0.size() > 0) ? drive_of(hq0[0], 1'b1) : drive_of('0, 1'b0);
        bus.h1_req_i = (hq1.size() > 0) ? drive_of(hq1[0], 1'b1) : drive_of('0, 1'b0);
        d = '0;
        d.a_ready = 1'b1;
        if (dev_pending && cyc >= dev_due) begin
            d.d_valid  = 1'b1;
            d.d_opcode = (dev_op == Get) ? AccessAckData : AccessAck;
            d.d_size   = 2'd2;
            d.d_source = dev_src;
            d.d_data   = dev_late ? 32'hDEAD_BEEF : ((dev_op == Get) ? dev_addr : 32'h0);
        end
        bus.dev_rsp_i = d;
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (((hq0.size() + hq1.size() + eq0.size() + eq1.size()) != 0 || dev_pending)
               && n < budget) begin
            step();
            n++;
        end
        chk("wait_budget", n < budget, 1);
        step();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"}, gnt, 2'b00);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_dev_a_valid"}, bus.dev_req_o.a_valid, 0);
        chk({tag, "_dev_d_ready"}, bus.dev_req_o.d_ready, 0);
        chk({tag, "_h0_a_ready"}, bus.h0_rsp_o.a_ready, 0);
        chk({tag, "_h0_d_valid"}, bus.h0_rsp_o.d_valid, 0);
        chk({tag, "_h1_a_ready"}, bus.h1_rsp_o.a_ready, 0);
        chk({tag, "_h1_d_valid"}, bus.h1_rsp_o.d_valid, 0);
    endtask

    initial begin
        bus.h0_req_i  = '0;
        bus.h1_req_i  = '0;
        bus.dev_rsp_i = '0;

        rst = 1'b1;
        repeat (3) step();
        chk_quiet("reset");
        rst = 1'b0;

        // Single host 0 write: one cycle of arbitration before the device sees it.
        dev_delay = 1;
        push_req(0, PutFullData, 32'd100, 32'd100, 1'b0);
        gq.push_back(0);
        step();
        chk("t1_idle_dev_a_valid", bus.dev_req_o.a_valid, 0);
        chk("t1_idle_gnt", gnt, 2'b00);
        step();
        chk("t1_addr_dev_a_valid", bus.dev_req_o.a_valid, 1);
        chk("t1_addr_address", bus.dev_req_o.a_address, 32'd100);
        chk("t1_addr_data", bus.dev_req_o.a_data, 32'd100);
        chk("t1_addr_gnt", gnt, 2'b01);
        step();
        chk("t1_resp_gnt", gnt, 2'b01);
        wait_idle(50);
        chk("t1_done_gnt", gnt, 2'b00);

        // Host 1 read with a 5-cycle device latency.
        dev_delay = 5;
        push_req(1, Get, 32'd200, 32'd0, 1'b0);
        gq.push_back(1);
        wait_idle(50);

        // Both hosts streaming: grants must alternate starting with host 0.
        dev_delay = 1;
        for (int i = 0; i < 4; i++) begin
            push_req(0, PutFullData, 32'h10, 32'(i + 1), 1'b0);
            push_req(1, Get, 32'h20, 32'd0, 1'b0);
            gq.push_back(0);
            gq.push_back(1);
        end
        wait_idle(200);

        // Silent device: timeout, error response, late response swallowed, then recovery.
        dev_silent = 1'b1;
        push_req(0, Get, 32'h40, 32'd0, 1'b1);
        gq.push_back(0);
        wait_idle(100);
        dev_silent = 1'b0;
        chk("t4_timeout_pulses", pulses, 1);
        push_req(0, PutFullData, 32'h44, 32'h1234, 1'b0);
        gq.push_back(0);
        wait_idle(50);

        // Response landing exactly on the expiry cycle completes normally.
        dev_delay = TO;
        push_req(1, Get, 32'h80, 32'd0, 1'b0);
        gq.push_back(1);
        wait_idle(50);
        chk("t5_timeout_pulses", pulses, 1);

        // Host 0 completes last, then reset mid-RESP must restore host-0-first priority.
        dev_delay = 1;
        push_req(0, PutFullData, 32'h50, 32'd5, 1'b0);
        gq.push_back(0);
        wait_idle(50);
        dev_delay = 40;
        push_req(0, Get, 32'h300, 32'd0, 1'b0);
        gq.push_back(0);
        repeat (3) step();
        chk("t6_resp_gnt", gnt, 2'b01);
        rst = 1'b1;
        step();
        chk_quiet("midrst");
        rst = 1'b0;
        eq0.delete();
        dev_pending = 1'b0;
        dev_delay   = 1;
        push_req(0, PutFullData, 32'h60, 32'd6, 1'b0);
        push_req(1, Get, 32'h70, 32'd0, 1'b0);
        gq.push_back(0);
        gq.push_back(1);
        wait_idle(100);

        chk("leftover", hq0.size() + hq1.size() + eq0.size() + eq1.size() + gq.size(), 0);
        chk("final_timeout_pulses", pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlul_host_arb2.md
Name: tlul_host_arb2

Overview:
- Two-requester TL-UL host arbiter. Shares one TL-UL device port between host 0 (spi_device_tlul bridge) and host 1 (second master, e.g. debug/DMA).
- Round-robin grant. One outstanding transaction at a time. Device-response timeout returns a synthesized error response to the host.
- Sits between the hosts and the crossbar/memory port.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait in RESP for d_valid before error return; 0 disables timeout.
- CNT_W, 16: timeout counter width; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- h0_req_i  input  tlul_pkg::tl_h2d_t  host 0 request (SPI bridge)
- h0_rsp_o  output  tlul_pkg::tl_d2h_t  host 0 response
- h1_req_i  input  tlul_pkg::tl_h2d_t  host 1 request
- h1_rsp_o  output  tlul_pkg::tl_d2h_t  host 1 response
- dev_req_o  output  tlul_pkg::tl_h2d_t  request to device
- dev_rsp_i  input  tlul_pkg::tl_d2h_t  response from device
- gnt_o  output  2  one-hot current owner (00 = none)
- timeout_o  output  1  one-cycle pulse on timeout

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - state = IDLE, last-winner = host 1 (so host 0 wins the first tie), timeout counter = 0.
  - dev_req_o.a_valid = 0, dev_req_o.d_ready = 0.
  - h0/h1 a_ready = 0, d_valid = 0. gnt_o = 00, timeout_o = 0.
- States: IDLE, ADDR, RESP, ERR, DRAIN.
- IDLE:
  - All a_ready = 0.
  - If exactly one host has a_valid, grant it. If both, grant the one not equal to last-winner.
  - Latch the grant into an owner register. Next state = ADDR. gnt_o updates the same cycle as the ADDR entry.
  - Grant decision is 1 cycle; arbitration adds 1 cycle of latency.
- ADDR:
  - dev_req_o mirrors the owner's a_* fields combinationally. Owner a_ready = dev_rsp_i.a_ready. Non-owner a_ready = 0.
  - On dev a_valid & a_ready: next state = RESP, counter cleared.
  - Owner dropping a_valid before handshake violates TL-UL; behaviour undefined.
- RESP:
  - dev_req_o.a_valid = 0. dev_req_o.d_ready = owner d_ready. Owner receives dev_rsp_i d_* fields. Non-owner d_valid = 0.
  - Counter increments each cycle without d_valid.
  - On d_valid & d_ready: last-winner = owner, next state = IDLE, gnt_o cleared next cycle.
  - When counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0) with no d_valid in that cycle: next state = ERR, timeout_o pulses 1 cycle.
  - d_valid in the same cycle as counter expiry wins: normal completion, no timeout.
- ERR:
  - Owner gets d_valid = 1, d_error = 1, d_data = 0xFFFFFFFF. d_source/d_size echo the latched request, d_opcode = AccessAckData for Get and AccessAck for Put.
  - Held until owner d_ready. Then last-winner = owner, next state = DRAIN.
- DRAIN:
  - dev d_ready = 1, both hosts d_valid = 0, no new grant.
  - Swallows one late device response, then next state = IDLE.
  - Leaves DRAIN after TIMEOUT_CYCLES more cycles without a response.
- Latched per grant: a_source, a_size, a_opcode (used for ERR).
- Simultaneous events:
  - New request arriving in the RESP-completion cycle is considered in the following IDLE cycle (no back-to-back same-cycle grant).
  - Back-to-back requests from both hosts strictly alternate.
- Reset mid-transaction:
  - All state is cleared within 1 cycle. An outstanding device response after reset is not routed (d_ready = 0 in IDLE).
  - The system resets device and hosts together.
- Pass-through fields (a_mask, a_param, a_user) are forwarded unchanged. No width conversion.

Test Plan:
- Single host 0 PutFullData addr 100, data 100 (SPI cmd 2 path) -> dev sees a_valid with a_address = 100, a_data = 100 one cycle after request; host 0 gets AccessAck; gnt_o = 01 during the transaction, then 00.
- Host 1 Get addr 200, device returns d_data = 200 after 5 cycles -> host 1 d_data = 200, d_error = 0; host 0 sees no d_valid throughout.
- Both hosts assert a_valid continuously for 4 transactions each (addresses 0x10, 0x20) -> grant order 0,1,0,1,...; no transaction lost or duplicated.
- Device never responds, TIMEOUT_CYCLES = 8 -> timeout_o pulses exactly 9 cycles after the A handshake; owner gets d_error = 1, d_data = 0xFFFFFFFF; late response at cycle 12 is swallowed; next grant proceeds normally.
- d_valid arrives on the exact expiry cycle -> normal response, timeout_o stays 0.
- rst_i asserted for 1 cycle while in RESP -> all outputs at reset values next cycle; next request from host 0 is granted first.
